fetch_unit: RTL

//  Instruction-fetch stage: owns the program counter, drives the instruction-memory address and

---
 rtl/riscv_pkg.sv | 21 ++
 rtl/fetch_fifo.sv | 67 ++++++
 rtl/fetch_unit.sv | 89 ++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32 fetch-side definitions: widths, reset PC, halt word, FSM states and buffer entry.
package riscv_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned ILEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [ILEN-1:0] INSTR_HALT       = 32'h0000_0000;

  typedef enum logic [1:0] {
    StBoot,
    StRun,
    StHalt
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// In-order fetch buffer: power-of-two depth, flush, simultaneous push+pop when full.
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter int unsigned Depth = 2
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         flush_i,
  input  logic         push_i,
  input  fetch_entry_t wdata_i,
  input  logic         pop_i,
  output logic         valid_o,
  output logic         full_o,
  output fetch_entry_t head_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  fetch_entry_t    mem_q [Depth];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            do_push, do_pop;

  assign valid_o = (count_q != '0);
  assign full_o  = (count_q == CntW'(Depth));
  assign do_pop  = pop_i & valid_o;
  // A pop in the same cycle frees the slot, so a full buffer can still accept.
  assign do_push = push_i & (~full_o | do_pop);
  assign head_o  = valid_o ? mem_q[rd_ptr_q] : '0;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < Depth; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (do_push && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, next-PC mux, boot/run/halt FSM and fetch-buffer push logic.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int unsigned     FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic [XLEN-1:0] imem_addr,
  input  logic [ILEN-1:0] imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [ILEN-1:0] if_instr,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_pc_plus4,
  output logic            halted
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            push, pop, flush, fifo_full;
  fetch_entry_t    head, wdata;

  assign imem_addr = pc_q;
  assign halted    = (state_q == StHalt);
  // Redirect wins over decode: the head is discarded, not delivered.
  assign pop       = if_valid & if_ready & ~redirect_valid;
  assign wdata     = '{pc: pc_q, instr: imem_rdata};

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    push    = 1'b0;
    flush   = 1'b0;
    if (redirect_valid) begin
      flush   = 1'b1;
      pc_d    = redirect_pc & ~XLEN'(3);
      state_d = StRun;
    end else begin
      unique case (state_q)
        StBoot: state_d = StRun;
        StRun: begin
          if (!fifo_full || pop) begin
            if (imem_rdata == INSTR_HALT) begin
              state_d = StHalt;
            end else begin
              push = 1'b1;
              pc_d = pc_q + XLEN'(4);
            end
          end
        end
        StHalt:  state_d = StHalt;
        default: state_d = StBoot;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StBoot;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  fetch_fifo #(
    .Depth(FIFO_DEPTH)
  ) u_fifo (
    .clk_i  (clk),
    .rst_ni (rst),
    .flush_i(flush),
    .push_i (push),
    .wdata_i(wdata),
    .pop_i  (pop),
    .valid_o(if_valid),
    .full_o (fifo_full),
    .head_o (head)
  );

  assign if_instr    = head.instr;
  assign if_pc       = head.pc;
  assign if_pc_plus4 = if_valid ? head.pc + XLEN'(4) : '0;

endmodule
